// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between the issue stage and its neighbours
// Signals: in_valid/in_ready/in_instr (instruction in), out_valid/out_ready/a/b/alu_op/out_rd
// (issued op), wb_valid/wb_rd/wb_data (ALU writeback), illegal/illegal_cnt/busy_mask (status).
// The slave modport is the issue stage; the master modport is whatever drives it.
interface alu_issue_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 8
);
    logic                     in_valid, in_ready;
    logic [15:0]              in_instr;
    logic                     out_valid, out_ready;
    logic [DATA_W-1:0]        a, b;
    logic [3:0]               alu_op;
    logic [$clog2(NREGS)-1:0] out_rd;
    logic                     wb_valid;
    logic [$clog2(NREGS)-1:0] wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic                     illegal;
    logic [CNT_W-1:0]         illegal_cnt;
    logic [NREGS-1:0]         busy_mask;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid, a, b, alu_op, out_rd, illegal, illegal_cnt, busy_mask
    );
    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
        output in_ready, out_valid, a, b, alu_op, out_rd, illegal, illegal_cnt, busy_mask
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode, hazard-check and issue instructions to the 16-bit ALU
// Ports: clk (rising edge), rst_n (async active-low), bus (alu_issue_if.slave):
// instruction in via in_*, issued op via out_*/a/b/alu_op, results back via wb_*,
// status on illegal (pulse), illegal_cnt (saturating) and busy_mask (scoreboard).
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam int IW = $clog2(NREGS);

    logic [3:0]        op;
    logic [IW-1:0]     rd, rs1, rs2;
    logic              is_alu, is_ill, wb_en, hazard, acc, acc_alu;
    logic [NREGS-1:0]  clr, set, eff_sb;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rd1, rd2;
    logic              out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [IW-1:0]     out_rd_q, out_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    assign op     = bus.in_instr[15:12];
    assign rd     = bus.in_instr[11:9];
    assign rs1    = bus.in_instr[8:6];
    assign rs2    = bus.in_instr[5:3];
    assign is_alu = (op != 4'd0) && (op <= 4'd10);
    assign is_ill = op > 4'd10;
    // r0 is never written, so a writeback to it neither updates state nor clears a bit
    assign wb_en  = bus.wb_valid && (bus.wb_rd != '0);
    assign clr    = wb_en ? NREGS'(1) << bus.wb_rd : '0;
    // a retiring writeback unblocks issue in the same cycle
    assign eff_sb = busy_q & ~clr;
    assign hazard = is_alu && (eff_sb[rs1] || eff_sb[rs2] || eff_sb[rd]);

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign acc          = bus.in_valid && bus.in_ready;
    assign acc_alu      = acc && is_alu;
    assign set          = (acc_alu && rd != '0) ? NREGS'(1) << rd : '0;

    // reads bypass the writeback value so a just-unblocked op sees fresh data
    assign rd1 = (rs1 == '0) ? '0 : (wb_en && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1];
    assign rd2 = (rs2 == '0) ? '0 : (wb_en && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2];

    always_comb begin
        out_valid_d = acc_alu ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        a_d         = acc_alu ? rd1 : a_q;
        b_d         = acc_alu ? rd2 : b_q;
        alu_op_d    = acc_alu ? op : alu_op_q;
        out_rd_d    = acc_alu ? rd : out_rd_q;
        illegal_d   = acc && is_ill;
        cnt_d       = (illegal_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        // set after clear: issuing to rd while rd retires keeps the bit busy
        busy_d      = eff_sb | set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_op_q    <= '0;
            out_rd_q    <= '0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_op_q    <= alu_op_d;
            out_rd_q    <= out_rd_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = cnt_q;
    assign bus.busy_mask   = busy_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus with a queue scoreboard checked by a monitor
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [2:0]  rd;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int ill_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.illegal) ill_seen++;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("issue expected", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("issue a", 32'(bus.a), 32'(e.a));
                    chk("issue b", 32'(bus.b), 32'(e.b));
                    chk("issue alu_op", 32'(bus.alu_op), 32'(e.op));
                    chk("issue out_rd", 32'(bus.out_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 1;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        #1 rst_n = 0;
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst a", 32'(bus.a), 0);
        chk("rst b", 32'(bus.b), 0);
        chk("rst alu_op", 32'(bus.alu_op), 0);
        chk("rst out_rd", 32'(bus.out_rd), 0);
        chk("rst illegal", 32'(bus.illegal), 0);
        chk("rst illegal_cnt", 32'(bus.illegal_cnt), 0);
        chk("rst busy_mask", 32'(bus.busy_mask), 0);
        tick;
        rst_n = 1;
        // 1: preload r1, r2 and issue ADD r3,r1,r2
        bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 16'h0005;
        tick;
        bus.wb_rd = 2; bus.wb_data = 16'h0003;
        tick;
        bus.wb_valid = 0;
        #1 chk("preload busy", 32'(bus.busy_mask), 32'h00);
        bus.in_valid = 1; bus.in_instr = 16'h1650;
        #1 chk("add in_ready", 32'(bus.in_ready), 1);
        q.push_back('{16'h0005, 16'h0003, 4'h1, 3'd3});
        tick;
        bus.in_valid = 0;
        #1;
        chk("add out_valid", 32'(bus.out_valid), 1);
        chk("add busy", 32'(bus.busy_mask), 32'h08);
        // 2: RAW stall on r3, then release by same-cycle writeback with bypass
        bus.in_valid = 1; bus.in_instr = 16'h28C8;
        repeat (3) begin
            #1 chk("raw in_ready", 32'(bus.in_ready), 0);
            tick;
        end
        bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 16'h0008;
        #1 chk("wb unblock in_ready", 32'(bus.in_ready), 1);
        q.push_back('{16'h0008, 16'h0005, 4'h2, 3'd4});
        tick;
        bus.wb_valid = 0;
        // 3: backpressure holds the SUB, then back-to-back issue
        bus.out_ready = 0; bus.in_instr = 16'h1A50;
        #1;
        chk("sub busy", 32'(bus.busy_mask), 32'h10);
        chk("sub out_valid", 32'(bus.out_valid), 1);
        repeat (2) begin
            tick;
            chk("hold a", 32'(bus.a), 32'h0008);
            chk("hold b", 32'(bus.b), 32'h0005);
            chk("hold alu_op", 32'(bus.alu_op), 2);
            chk("hold out_rd", 32'(bus.out_rd), 4);
            chk("hold in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1;
        #1 chk("b2b in_ready", 32'(bus.in_ready), 1);
        q.push_back('{16'h0005, 16'h0003, 4'h1, 3'd5});
        tick;
        bus.in_valid = 0;
        #1;
        chk("b2b out_valid", 32'(bus.out_valid), 1);
        chk("b2b busy", 32'(bus.busy_mask), 32'h30);
        // 4: r0 reads as zero, never busy, ignores writeback
        bus.in_valid = 1; bus.in_instr = 16'h1008;
        q.push_back('{16'h0000, 16'h0005, 4'h1, 3'd0});
        tick;
        bus.in_valid = 0;
        #1 chk("r0 busy", 32'(bus.busy_mask), 32'h30);
        bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 16'hFFFF;
        tick;
        bus.in_valid = 1; bus.in_instr = 16'h1C00;
        q.push_back('{16'h0000, 16'h0000, 4'h1, 3'd6});
        tick;
        bus.in_valid = 0; bus.wb_valid = 0;
        #1 chk("r6 busy", 32'(bus.busy_mask), 32'h70);
        // 5: 300 illegal words saturate the counter, then a NOP
        ill_seen = 0;
        bus.in_valid = 1; bus.in_instr = 16'hF000;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (i == 9) chk("ill cnt 10", 32'(bus.illegal_cnt), 10);
        end
        chk("ill pulse", 32'(bus.illegal), 1);
        bus.in_instr = 16'h0000;
        #1 chk("nop in_ready", 32'(bus.in_ready), 1);
        tick;
        bus.in_valid = 0;
        #1;
        chk("nop out_valid", 32'(bus.out_valid), 0);
        chk("nop illegal", 32'(bus.illegal), 0);
        chk("ill cnt sat", 32'(bus.illegal_cnt), 255);
        tick;
        chk("ill pulses", 32'(ill_seen), 300);
        // 6: async reset while an op is in flight
        bus.wb_valid = 1; bus.wb_data = 16'h1234;
        for (int r = 4; r <= 6; r++) begin
            bus.wb_rd = 3'(r);
            tick;
        end
        bus.wb_valid = 0;
        bus.in_valid = 1; bus.in_instr = 16'h1650;
        q.push_back('{16'h0005, 16'h0003, 4'h1, 3'd3});
        tick;
        bus.in_instr = 16'h1850;
        tick;
        bus.in_valid = 0; bus.out_ready = 0;
        #1;
        chk("pre-rst busy", 32'(bus.busy_mask), 32'h18);
        chk("pre-rst out_valid", 32'(bus.out_valid), 1);
        rst_n = 0;
        #1;
        chk("async out_valid", 32'(bus.out_valid), 0);
        chk("async busy", 32'(bus.busy_mask), 0);
        chk("async a", 32'(bus.a), 0);
        chk("async alu_op", 32'(bus.alu_op), 0);
        chk("async illegal_cnt", 32'(bus.illegal_cnt), 0);
        tick;
        rst_n = 1; bus.out_ready = 1;
        bus.in_valid = 1; bus.in_instr = 16'h1E48;
        q.push_back('{16'h0000, 16'h0000, 4'h1, 3'd7});
        tick;
        bus.in_valid = 0;
        #1;
        chk("post-rst a", 32'(bus.a), 0);
        chk("post-rst busy", 32'(bus.busy_mask), 32'h80);
        tick;
        tick;
        chk("queue drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
